qpu_exu_moitf: RTL and testbench
================================

# qpu_exu_moitf

Measure outstanding-instruction tracking FIFO (MOITF) for the QPU execution unit. Dispatch allocates one entry per measure instruction, holding that instruction's qubit list. The block tells dispatch whether a new qubit-flag reader (measure/FMR) overlaps any pending measurement, and retires entries in order as measurement results return. It paces measure dispatch by backpressure and keeps the aggregate pending-qubit flag.

## Interface
- DEPTH, default 4: number of entries; power of two, ≥2.
- QW, default `QPU_QUBIT_NUM: qubit-list width.
- TIMEOUT, default 1024: head-entry watchdog limit in cycles; used only with the timeout feature.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- dis_ena  in  1  allocate entry this cycle; the measure instruction is being dispatched.
- dis_qubitlist  in  QW  qubit list stored on allocation.
- dis_ready  out  1  entry available (not full).
- dis_ptr  out  log2(DEPTH)  index the next allocation will use.
- dis_qfren  in  1  the dispatching instruction reads the qubit flag.
- dis_ql  in  QW  qubit list of the dispatching instruction.
- match_dispql  out  1  overlap between dis_ql and pending qubits.
- ret_ena  in  1  measurement result for the head entry returned.
- ret_qubitlist  out  QW  qubit list of the head entry.
- ret_ptr  out  log2(DEPTH)  head index.
- empty  out  1  no entries valid.
- qubitflag  out  QW  OR of qubit lists of all valid entries.
- tmo_err  out  1  sticky watchdog error; tied 0 when the feature is compiled out.

## Operation
- State:
  - write and read pointers, each log2(DEPTH) bits plus a wrap bit;
  - per-entry valid bit;
  - per-entry QW-bit qubit list.
- Flags:
  - empty = pointers equal including wrap bit.
  - full = indices equal and wrap bits differ.
  - dis_ready = ~full.
- Allocate when dis_ena & ~full:
  - store dis_qubitlist at the write index and set its valid bit;
  - advance the write pointer, toggling the wrap bit at DEPTH-1 → 0.
- Retire when ret_ena & ~empty:
  - clear the head valid bit and advance the read pointer, with the same wrap rule.
- Protocol errors:
  - dis_ena while full is ignored: no state change.
  - ret_ena while empty is ignored.
- Allocate and retire in the same cycle: both take effect.
  - When full, dis_ready stays 0 even if a retire occurs that cycle; there is no same-cycle bypass.
  - When empty, a same-cycle allocate is not retired; the retire is ignored.
- qubitflag = OR over i of (valid[i] ? list[i] : 0).
- match_dispql = dis_qfren & |(dis_ql & qubitflag).
- ret_qubitlist shows the head entry's list; it is 0 when empty.
- Pointer width arithmetic is modulo 2·DEPTH; no other counters exist in the base block.

## Timing
- All outputs except match_dispql are functions of registers only.
- match_dispql is combinational from dis_qfren, dis_ql and registers. Dispatch uses it in the same cycle.
- Allocation latency: the entry is visible in qubitflag, match_dispql, empty and dis_ready the cycle after dis_ena.
- Retire latency: the entry is cleared from qubitflag the cycle after ret_ena.
- Values after rst (applied on the next clock edge):
  - pointers 0, all valid 0;
  - dis_ready=1, empty=1, qubitflag=0, match_dispql=0, ret_qubitlist=0, dis_ptr=0, ret_ptr=0, tmo_err=0.
- Reset mid-operation discards all entries without retire handshakes. Stored list contents need not be cleared, since valid gates them.

## Configuration
- QPU_MOITF_TIMEOUT_EN defined:
  - A head-age counter of width clog2(TIMEOUT+1) increments each cycle that ~empty & ~ret_ena.
  - It clears to 0 on a successful retire, when empty, or on rst.
  - When it reaches TIMEOUT, tmo_err sets; tmo_err is sticky until rst.
  - The counter saturates at TIMEOUT.
- QPU_MOITF_TIMEOUT_EN undefined: no counter is built and tmo_err is constant 0.

## Structure
- Shared defines go in QPU_defines.v:
  - `QPU_MOITF_DEPTH and `QPU_MOITF_PTR_WIDTH;
  - `QPU_QUBIT_NUM (existing).
- One sub-module, qpu_moitf_ptr: pointer register with wrap bit, inputs inc/rst, parameter DEPTH. It is instantiated twice, once for the write pointer and once for the read pointer.
- Entry storage and the OR-reduction stay in the top module as a flop array.

## Test plan
- Reset, then idle → dis_ready=1, empty=1, qubitflag=0, tmo_err=0.
- QW=8, DEPTH=4. Allocate lists 0x01, 0x02, 0x04, 0x08 on consecutive cycles → after the 4th, dis_ready=0 and qubitflag=0x0F. A 5th dis_ena is ignored.
- With 0x03 pending, dis_qfren=1 and dis_ql=0x02 → match_dispql=1 in the same cycle. dis_ql=0x04 → 0. dis_qfren=0 → 0.
- Full FIFO, ret_ena and dis_ena in the same cycle → only the retire occurs. Next cycle dis_ready=1 and ret_ptr=1.
- Run 10 allocate/retire pairs with DEPTH=4 → pointers wrap twice; retire order matches allocation order via ret_qubitlist. Ends with empty=1.
- With QPU_MOITF_TIMEOUT_EN and TIMEOUT=8, allocate one entry and never retire → tmo_err=1 from cycle 8 after allocation and stays 1 after a later retire. It clears only on rst.

Source files
------------

// File: rtl/qpu_exu_moitf_pkg.sv
// Shared QPU defines and MOITF constants. The optional head-entry watchdog is
// compiled in with QPU_MOITF_TIMEOUT_EN.
`ifndef QPU_QUBIT_NUM
`define QPU_QUBIT_NUM 8
`endif
`ifndef QPU_MOITF_DEPTH
`define QPU_MOITF_DEPTH 4
`endif
`ifndef QPU_MOITF_PTR_WIDTH
`define QPU_MOITF_PTR_WIDTH 2
`endif

package qpu_exu_moitf_pkg;
   localparam int unsigned MOITF_DEPTH   = `QPU_MOITF_DEPTH;
   localparam int unsigned MOITF_PTR_W   = `QPU_MOITF_PTR_WIDTH;
   localparam int unsigned QUBIT_NUM     = `QPU_QUBIT_NUM;
   localparam int unsigned MOITF_TIMEOUT = 1024;

   // Index part of a wrap-extended pointer.
   function automatic int unsigned ptr_idx(input int unsigned ptr, input int unsigned depth);
      return ptr % depth;
   endfunction
endpackage

// File: rtl/qpu_exu_moitf_if.sv
// Dispatch/retire interface of the measure outstanding-instruction FIFO.
import qpu_exu_moitf_pkg::*;

interface qpu_exu_moitf_if #(
   parameter int unsigned QW = QUBIT_NUM,
   parameter int unsigned PW = MOITF_PTR_W
);
   logic          dis_ena;
   logic [QW-1:0] dis_qubitlist;
   logic          dis_ready;
   logic [PW-1:0] dis_ptr;
   logic          dis_qfren;
   logic [QW-1:0] dis_ql;
   logic          match_dispql;
   logic          ret_ena;
   logic [QW-1:0] ret_qubitlist;
   logic [PW-1:0] ret_ptr;
   logic          empty;
   logic [QW-1:0] qubitflag;
   logic          tmo_err;

   modport master (
      output dis_ena, dis_qubitlist, dis_qfren, dis_ql, ret_ena,
      input  dis_ready, dis_ptr, match_dispql, ret_qubitlist, ret_ptr,
             empty, qubitflag, tmo_err
   );

   modport slave (
      input  dis_ena, dis_qubitlist, dis_qfren, dis_ql, ret_ena,
      output dis_ready, dis_ptr, match_dispql, ret_qubitlist, ret_ptr,
             empty, qubitflag, tmo_err
   );
endinterface

// File: rtl/qpu_moitf_ptr.sv
// FIFO pointer register: log2(DEPTH) index bits plus a wrap bit.
import qpu_exu_moitf_pkg::*;

module qpu_moitf_ptr #(
   parameter int unsigned DEPTH = MOITF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inc,
   output logic [$clog2(DEPTH):0] ptr
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] ONE = {{PW{1'b0}}, 1'b1};

   // DEPTH is a power of two, so natural overflow toggles the wrap bit.
   always_ff @(posedge clk) begin
      if (rst)      ptr <= '0;
      else if (inc) ptr <= ptr + ONE;
   end
endmodule

// File: rtl/qpu_exu_moitf.sv
// Measure outstanding-instruction tracking FIFO for the QPU execution unit.
// Define QPU_MOITF_TIMEOUT_EN to build the head-entry watchdog (tmo_err).
import qpu_exu_moitf_pkg::*;

module qpu_exu_moitf #(
   parameter int unsigned DEPTH   = MOITF_DEPTH,
   parameter int unsigned QW      = QUBIT_NUM,
   parameter int unsigned TIMEOUT = MOITF_TIMEOUT
) (
   input logic          clk,
   input logic          rst,
   qpu_exu_moitf_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW:0]       wptr, rptr;
   logic [PW-1:0]     widx, ridx;
   logic              full, empty, alloc, retire;
   logic [DEPTH-1:0]  valid;
   logic [QW-1:0]     list [DEPTH];
   logic [QW-1:0]     qubitflag;

   assign widx   = wptr[PW-1:0];
   assign ridx   = rptr[PW-1:0];
   assign empty  = (wptr == rptr);
   assign full   = (widx == ridx) && (wptr[PW] != rptr[PW]);
   assign alloc  = bus.dis_ena & ~full;
   assign retire = bus.ret_ena & ~empty;

   qpu_moitf_ptr #(.DEPTH(DEPTH)) u_wptr (.clk(clk), .rst(rst), .inc(alloc),  .ptr(wptr));
   qpu_moitf_ptr #(.DEPTH(DEPTH)) u_rptr (.clk(clk), .rst(rst), .inc(retire), .ptr(rptr));

   // Alloc and retire can only hit the same index when full or empty, where one is blocked.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else begin
         if (retire) valid[ridx] <= 1'b0;
         if (alloc)  valid[widx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc) list[widx] <= bus.dis_qubitlist;
   end

   always_comb begin
      qubitflag = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid[i]) qubitflag = qubitflag | list[i];
      end
   end

   assign bus.qubitflag     = qubitflag;
   assign bus.match_dispql  = bus.dis_qfren & (|(bus.dis_ql & qubitflag));
   assign bus.dis_ready     = ~full;
   assign bus.dis_ptr       = widx;
   assign bus.ret_ptr       = ridx;
   assign bus.empty         = empty;
   assign bus.ret_qubitlist = empty ? '0 : list[ridx];

`ifdef QPU_MOITF_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [CW-1:0] age, age_nxt;
   logic          tmo_err;

   always_comb begin
      age_nxt = age;
      if (empty || retire)  age_nxt = '0;
      else if (age != TMO)  age_nxt = age + CNT_ONE;
   end

   // Error rises together with the counter reaching TIMEOUT, not a cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         age     <= '0;
         tmo_err <= 1'b0;
      end else begin
         age     <= age_nxt;
         tmo_err <= tmo_err | (age_nxt == TMO);
      end
   end

   assign bus.tmo_err = tmo_err;
`else
   assign bus.tmo_err = 1'b0;
`endif
endmodule

// File: tb/tb_qpu_exu_moitf.sv
// Directed self-checking bench for qpu_exu_moitf (DEPTH=4, QW=8).
// With QPU_MOITF_TIMEOUT_EN defined it also exercises the watchdog at TIMEOUT=8.
import qpu_exu_moitf_pkg::*;

module tb_qpu_exu_moitf;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned QW    = 8;
   localparam int unsigned PW    = 2;
`ifdef QPU_MOITF_TIMEOUT_EN
   localparam int unsigned TMO = 8;
`else
   localparam int unsigned TMO = 1024;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_chk  = 0;

   always #5 clk = ~clk;

   qpu_exu_moitf_if #(.QW(QW), .PW(PW)) bus ();

   qpu_exu_moitf #(.DEPTH(DEPTH), .QW(QW), .TIMEOUT(TMO)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.dis_ena = 1'b0; bus.dis_qubitlist = '0;
      bus.dis_qfren = 1'b0; bus.dis_ql = '0; bus.ret_ena = 1'b0;
   endtask

   task automatic alloc(input logic [QW-1:0] q);
      bus.dis_ena = 1'b1; bus.dis_qubitlist = q;
      step();
      bus.dis_ena = 1'b0;
   endtask

   task automatic retire();
      bus.ret_ena = 1'b1;
      step();
      bus.ret_ena = 1'b0;
   endtask

   initial begin
      logic [QW-1:0] v;
      idle_inputs();
      step(); step();
      rst = 1'b0;
      #1;
      check("rst_dis_ready", 32'(bus.dis_ready), 32'd1);
      check("rst_empty",     32'(bus.empty), 32'd1);
      check("rst_qubitflag", 32'(bus.qubitflag), 32'h0);
      check("rst_ret_ql",    32'(bus.ret_qubitlist), 32'h0);
      check("rst_dis_ptr",   32'(bus.dis_ptr), 32'd0);
      check("rst_ret_ptr",   32'(bus.ret_ptr), 32'd0);
      check("rst_tmo_err",   32'(bus.tmo_err), 32'd0);
      bus.dis_qfren = 1'b1; bus.dis_ql = 8'hFF; #1;
      check("rst_match", 32'(bus.match_dispql), 32'd0);
      bus.dis_qfren = 1'b0; bus.dis_ql = '0;

      // Fill the FIFO
      alloc(8'h01);
      check("a1_empty",   32'(bus.empty), 32'd0);
      check("a1_flag",    32'(bus.qubitflag), 32'h01);
      check("a1_dis_ptr", 32'(bus.dis_ptr), 32'd1);
      alloc(8'h02);
      alloc(8'h04);
      check("a3_ready",   32'(bus.dis_ready), 32'd1);
      alloc(8'h08);
      check("full_ready", 32'(bus.dis_ready), 32'd0);
      check("full_flag",  32'(bus.qubitflag), 32'h0F);
      check("full_dptr",  32'(bus.dis_ptr), 32'd0);
      check("full_head",  32'(bus.ret_qubitlist), 32'h01);
      alloc(8'h80);
      check("ovf_flag",   32'(bus.qubitflag), 32'h0F);
      check("ovf_dptr",   32'(bus.dis_ptr), 32'd0);
      check("ovf_ready",  32'(bus.dis_ready), 32'd0);

      // Same-cycle match against pending qubits
      bus.dis_qfren = 1'b1; bus.dis_ql = 8'h02; #1;
      check("match_hit",  32'(bus.match_dispql), 32'd1);
      bus.dis_ql = 8'h30; #1;
      check("match_miss", 32'(bus.match_dispql), 32'd0);
      bus.dis_qfren = 1'b0; bus.dis_ql = 8'h02; #1;
      check("match_noren", 32'(bus.match_dispql), 32'd0);
      bus.dis_ql = '0;

      // Full: retire and dispatch together, only the retire lands
      bus.dis_ena = 1'b1; bus.dis_qubitlist = 8'h40; bus.ret_ena = 1'b1;
      step();
      idle_inputs();
      check("fr_ready",  32'(bus.dis_ready), 32'd1);
      check("fr_rptr",   32'(bus.ret_ptr), 32'd1);
      check("fr_dptr",   32'(bus.dis_ptr), 32'd0);
      check("fr_flag",   32'(bus.qubitflag), 32'h0E);
      check("fr_head",   32'(bus.ret_qubitlist), 32'h02);

      retire();
      check("d1_head", 32'(bus.ret_qubitlist), 32'h04);
      check("d1_flag", 32'(bus.qubitflag), 32'h0C);
      retire();
      check("d2_head", 32'(bus.ret_qubitlist), 32'h08);
      retire();
      check("d3_empty", 32'(bus.empty), 32'd1);
      check("d3_flag",  32'(bus.qubitflag), 32'h0);
      check("d3_head",  32'(bus.ret_qubitlist), 32'h0);
      retire();
      check("uf_rptr",  32'(bus.ret_ptr), 32'd0);
      check("uf_empty", 32'(bus.empty), 32'd1);

      // Empty: same-cycle allocate is not retired
      bus.dis_ena = 1'b1; bus.dis_qubitlist = 8'h03; bus.ret_ena = 1'b1;
      step();
      idle_inputs();
      check("er_empty", 32'(bus.empty), 32'd0);
      check("er_flag",  32'(bus.qubitflag), 32'h03);
      check("er_head",  32'(bus.ret_qubitlist), 32'h03);
      bus.dis_qfren = 1'b1; bus.dis_ql = 8'h02; #1;
      check("m03_hit",  32'(bus.match_dispql), 32'd1);
      bus.dis_ql = 8'h04; #1;
      check("m03_miss", 32'(bus.match_dispql), 32'd0);
      bus.dis_qfren = 1'b0; bus.dis_ql = 8'h02; #1;
      check("m03_noren", 32'(bus.match_dispql), 32'd0);
      idle_inputs();
      retire();
      check("er_drain", 32'(bus.empty), 32'd1);

      // Ten allocate/retire pairs: pointers run 5 -> 15, wrapping twice
      for (int i = 0; i < 10; i++) begin
         v = 8'h10 + 8'(i);
         alloc(v);
         check("pair_head", 32'(bus.ret_qubitlist), 32'(v));
         retire();
      end
      check("pair_empty", 32'(bus.empty), 32'd1);
      check("pair_rptr",  32'(bus.ret_ptr), 32'd3);
      check("pair_dptr",  32'(bus.dis_ptr), 32'd3);

      // Reset discards pending entries
      alloc(8'h55);
      rst = 1'b1; step(); rst = 1'b0;
      check("mr_empty", 32'(bus.empty), 32'd1);
      check("mr_flag",  32'(bus.qubitflag), 32'h0);
      check("mr_dptr",  32'(bus.dis_ptr), 32'd0);

`ifdef QPU_MOITF_TIMEOUT_EN
      alloc(8'h01);
      repeat (7) step();
      check("tmo_early", 32'(bus.tmo_err), 32'd0);
      step();
      check("tmo_set",   32'(bus.tmo_err), 32'd1);
      retire();
      check("tmo_sticky", 32'(bus.tmo_err), 32'd1);
      rst = 1'b1; step(); rst = 1'b0;
      check("tmo_clear", 32'(bus.tmo_err), 32'd0);
`else
      alloc(8'h01);
      repeat (20) step();
      check("tmo_off", 32'(bus.tmo_err), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
